// File: rtl/pifo_reg_pushout_if.sv
// Bus interface for pifo_reg_pushout.
// master : producer side (drives insert/remove/rank_in/meta_in, observes status)
// slave  : the PIFO itself
//   insert, remove    : enqueue / dequeue-head requests, one per cycle
//   rank_in, meta_in  : entry being inserted
//   rank_out, meta_out, valid_out : registered head entry (0 when empty)
//   count, full, empty            : registered occupancy status
//   drop_valid, drop_rank, drop_meta : one-cycle report of a discarded entry
//   stat_insert_cnt, stat_drop_cnt   : optional saturating statistics
interface pifo_reg_pushout_if #(
  parameter int L2_MAX_SIZE = 3,
  parameter int RANK_WIDTH  = 8,
  parameter int META_WIDTH  = 8,
  parameter int STAT_WIDTH  = 32
);
  logic                   insert;
  logic                   remove;
  logic [RANK_WIDTH-1:0]  rank_in;
  logic [META_WIDTH-1:0]  meta_in;
  logic [RANK_WIDTH-1:0]  rank_out;
  logic [META_WIDTH-1:0]  meta_out;
  logic                   valid_out;
  logic [L2_MAX_SIZE:0]   count;
  logic                   full;
  logic                   empty;
  logic                   drop_valid;
  logic [RANK_WIDTH-1:0]  drop_rank;
  logic [META_WIDTH-1:0]  drop_meta;
  logic [STAT_WIDTH-1:0]  stat_insert_cnt;
  logic [STAT_WIDTH-1:0]  stat_drop_cnt;

  modport master (
    output insert, remove, rank_in, meta_in,
    input  rank_out, meta_out, valid_out, count, full, empty,
           drop_valid, drop_rank, drop_meta, stat_insert_cnt, stat_drop_cnt
  );

  modport slave (
    input  insert, remove, rank_in, meta_in,
    output rank_out, meta_out, valid_out, count, full, empty,
           drop_valid, drop_rank, drop_meta, stat_insert_cnt, stat_drop_cnt
  );
endinterface

// File: rtl/pifo_reg_pushout.sv
// Register-array PIFO with push-out overflow policy.
// Holds up to 2**L2_MAX_SIZE {rank, meta} entries sorted best-first; slot 0 is
// the head. Ties are FIFO (a new entry goes behind equal ranks). Insert and
// remove in the same cycle pop the current head and sort the new entry into
// the remainder, so a full queue never drops in that case. When full with a
// lone insert, OVF_MODE "TAIL" drops the arrival, "PUSHOUT" evicts the tail if
// the arrival is strictly better. Every discard is reported on drop_*.
// Ports: clk, rst (sync, active high), bus (pifo_reg_pushout_if.slave).
// Optional feature macro: PIFO_REG_STATS_EN enables saturating insert/drop
// counters; without it the stat ports are tied to 0.

// One storage slot. Next value is picked from the post-pop view of the array:
// stay (entry is not worse than the arrival), take the arrival (first slot
// where the arrival is better), or take the neighbour above (shifted down).
module pifo_reg_pushout_cell #(
  parameter int EW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          upd,      // array changes this cycle
  input  logic          ins,      // an arrival is being sorted in
  input  logic          vld_nxt,  // slot holds an entry after this cycle
  input  logic          le_self,  // own post-pop entry stays ahead of arrival
  input  logic          le_prev,  // slot above stays ahead (1 for slot 0)
  input  logic [EW-1:0] sh_self,
  input  logic [EW-1:0] sh_prev,
  input  logic [EW-1:0] ent_new,
  output logic [EW-1:0] q
);
  logic [EW-1:0] d;

  always_comb begin
    d = sh_self;
    if (ins && !le_self) d = le_prev ? ent_new : sh_prev;
    // empty slots are kept at zero so the head reads 0 when the queue is empty
    if (!vld_nxt) d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst)      q <= '0;
    else if (upd) q <= d;
  end
endmodule

module pifo_reg_pushout #(
  parameter int    L2_MAX_SIZE = 3,
  parameter int    RANK_WIDTH  = 8,
  parameter int    META_WIDTH  = 8,
  parameter string ORDER       = "MIN",
  parameter string OVF_MODE    = "TAIL",
  parameter int    STAT_WIDTH  = 32
) (
  input logic               clk,
  input logic               rst,
  pifo_reg_pushout_if.slave bus
);
  localparam int DEPTH   = 2**L2_MAX_SIZE;
  localparam int CW      = L2_MAX_SIZE + 1;
  localparam int EW      = RANK_WIDTH + META_WIDTH;
  localparam bit IS_MIN  = (ORDER == "MIN");
  localparam bit PUSHOUT = (OVF_MODE == "PUSHOUT");

  typedef struct packed {
    logic [RANK_WIDTH-1:0] rank;
    logic [META_WIDTH-1:0] meta;
  } ent_t;

  function automatic logic better(input logic [RANK_WIDTH-1:0] a,
                                  input logic [RANK_WIDTH-1:0] b);
    return IS_MIN ? (a < b) : (a > b);
  endfunction

  ent_t [DEPTH-1:0] slot;     // registered contents
  ent_t [DEPTH-1:0] sh;       // contents after the optional pop
  ent_t [DEPTH-1:0] sh_up;    // sh shifted by one (slot i sees sh[i-1])
  logic [DEPTH-1:0] sh_vld;
  logic [DEPTH-1:0] le;       // post-pop entry is not worse than arrival
  logic [DEPTH-1:0] le_up;
  logic [DEPTH-1:0] vld_nxt;
  ent_t             ent_new;

  logic [CW-1:0] count_q, count_sh, count_nxt;
  logic          full_q, empty_q, valid_q;
  logic          pop, ovf, evict, tail_drop, ins_acc, upd;
  logic          drop_q;
  ent_t          drop_ent_q;

  assign ent_new = '{rank: bus.rank_in, meta: bus.meta_in};

  // remove on an empty queue is a no-op; full+insert without a pop overflows
  assign pop       = bus.remove && !empty_q;
  assign ovf       = bus.insert && full_q && !pop;
  assign evict     = ovf && PUSHOUT && better(bus.rank_in, slot[DEPTH-1].rank);
  assign tail_drop = ovf && !evict;
  assign ins_acc   = bus.insert && !tail_drop;
  assign upd       = pop || ins_acc;

  // an eviction swaps tail for arrival, so occupancy stays at DEPTH
  assign count_sh  = count_q - CW'(pop);
  assign count_nxt = count_sh + CW'(ins_acc && !evict);

  for (genvar i = 0; i < DEPTH; i++) begin : g_view
    if (i == DEPTH-1) begin : g_last
      assign sh[i] = pop ? ent_t'('0) : slot[i];
    end else begin : g_mid
      assign sh[i] = pop ? slot[i+1] : slot[i];
    end
    if (i == 0) begin : g_top
      assign sh_up[i] = '0;
      assign le_up[i] = 1'b1;
    end else begin : g_below
      assign sh_up[i] = sh[i-1];
      assign le_up[i] = le[i-1];
    end
    assign sh_vld[i]  = count_sh > CW'(i);
    assign vld_nxt[i] = count_nxt > CW'(i);
    // FIFO among ties: equal ranks stay ahead of the arrival
    assign le[i]      = sh_vld[i] && !better(bus.rank_in, sh[i].rank);

    pifo_reg_pushout_cell #(.EW(EW)) u_cell (
      .clk     (clk),
      .rst     (rst),
      .upd     (upd),
      .ins     (ins_acc),
      .vld_nxt (vld_nxt[i]),
      .le_self (le[i]),
      .le_prev (le_up[i]),
      .sh_self (sh[i]),
      .sh_prev (sh_up[i]),
      .ent_new (ent_new),
      .q       (slot[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      valid_q    <= 1'b0;
      drop_q     <= 1'b0;
      drop_ent_q <= '0;
    end else begin
      count_q <= count_nxt;
      full_q  <= (count_nxt == CW'(DEPTH));
      empty_q <= (count_nxt == '0);
      valid_q <= (count_nxt != '0);
      drop_q  <= evict || tail_drop;
      // drop_rank/meta hold their last value between pulses
      if (evict)          drop_ent_q <= slot[DEPTH-1];
      else if (tail_drop) drop_ent_q <= ent_new;
    end
  end

  assign bus.rank_out   = slot[0].rank;
  assign bus.meta_out   = slot[0].meta;
  assign bus.valid_out  = valid_q;
  assign bus.count      = count_q;
  assign bus.full       = full_q;
  assign bus.empty      = empty_q;
  assign bus.drop_valid = drop_q;
  assign bus.drop_rank  = drop_ent_q.rank;
  assign bus.drop_meta  = drop_ent_q.meta;

`ifdef PIFO_REG_STATS_EN
  logic [STAT_WIDTH-1:0] stat_ins_q, stat_drop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ins_q  <= '0;
      stat_drop_q <= '0;
    end else begin
      if (ins_acc && !(&stat_ins_q))
        stat_ins_q <= stat_ins_q + STAT_WIDTH'(1);
      if ((evict || tail_drop) && !(&stat_drop_q))
        stat_drop_q <= stat_drop_q + STAT_WIDTH'(1);
    end
  end

  assign bus.stat_insert_cnt = stat_ins_q;
  assign bus.stat_drop_cnt   = stat_drop_q;
`else
  assign bus.stat_insert_cnt = '0;
  assign bus.stat_drop_cnt   = '0;
`endif
endmodule

// File: tb/tb_pifo_reg_pushout.sv
// Bench for pifo_reg_pushout: a TAIL and a PUSHOUT instance (both ORDER=MIN,
// depth 8) see identical stimulus; each is compared to a sorted-array model.
module tb_pifo_reg_pushout;
  localparam int L2 = 3, RW = 8, MW = 8, SW = 32, DEPTH = 8, PW = 104;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pifo_reg_pushout_if #(.L2_MAX_SIZE(L2), .RANK_WIDTH(RW), .META_WIDTH(MW),
                        .STAT_WIDTH(SW)) bt ();
  pifo_reg_pushout_if #(.L2_MAX_SIZE(L2), .RANK_WIDTH(RW), .META_WIDTH(MW),
                        .STAT_WIDTH(SW)) bp ();

  pifo_reg_pushout #(.L2_MAX_SIZE(L2), .RANK_WIDTH(RW), .META_WIDTH(MW),
                     .ORDER("MIN"), .OVF_MODE("TAIL"), .STAT_WIDTH(SW))
    u_tail (.clk(clk), .rst(rst), .bus(bt.slave));
  pifo_reg_pushout #(.L2_MAX_SIZE(L2), .RANK_WIDTH(RW), .META_WIDTH(MW),
                     .ORDER("MIN"), .OVF_MODE("PUSHOUT"), .STAT_WIDTH(SW))
    u_push (.clk(clk), .rst(rst), .bus(bp.slave));

  // index 0 = TAIL instance, 1 = PUSHOUT instance
  logic [RW-1:0] a_rank[2], a_drank[2];
  logic [MW-1:0] a_meta[2], a_dmeta[2];
  logic [L2:0]   a_cnt[2];
  logic          a_full[2], a_empty[2], a_vo[2], a_dv[2];
  logic [SW-1:0] a_si[2], a_sd[2];

  assign a_rank[0] = bt.rank_out;   assign a_rank[1] = bp.rank_out;
  assign a_meta[0] = bt.meta_out;   assign a_meta[1] = bp.meta_out;
  assign a_drank[0] = bt.drop_rank; assign a_drank[1] = bp.drop_rank;
  assign a_dmeta[0] = bt.drop_meta; assign a_dmeta[1] = bp.drop_meta;
  assign a_cnt[0] = bt.count;       assign a_cnt[1] = bp.count;
  assign a_full[0] = bt.full;       assign a_full[1] = bp.full;
  assign a_empty[0] = bt.empty;     assign a_empty[1] = bp.empty;
  assign a_vo[0] = bt.valid_out;    assign a_vo[1] = bp.valid_out;
  assign a_dv[0] = bt.drop_valid;   assign a_dv[1] = bp.drop_valid;
  assign a_si[0] = bt.stat_insert_cnt; assign a_si[1] = bp.stat_insert_cnt;
  assign a_sd[0] = bt.stat_drop_cnt;   assign a_sd[1] = bp.stat_drop_cnt;

  // reference model: plain sorted arrays, best (smallest) rank first
  int mr[2][DEPTH], mm[2][DEPTH], mc[2];
  int e_dr[2], e_dm[2], e_si[2], e_sd[2];
  bit e_dv[2];
  int vectors = 0, errs = 0;

  task automatic model_step(input int d, input bit ins, input bit rem,
                            input int rk, input int mt);
    bit room;
    int pos;
    e_dv[d] = 1'b0;
    if (rem && mc[d] > 0) begin
      for (int i = 0; i < DEPTH-1; i++) begin
        mr[d][i] = mr[d][i+1];
        mm[d][i] = mm[d][i+1];
      end
      mc[d]--;
    end
    if (ins) begin
      room = mc[d] < DEPTH;
      if (!room && d == 1 && rk < mr[d][DEPTH-1]) begin
        e_dv[d] = 1'b1; e_dr[d] = mr[d][DEPTH-1]; e_dm[d] = mm[d][DEPTH-1];
        mc[d]--;
        room = 1'b1;
      end else if (!room) begin
        e_dv[d] = 1'b1; e_dr[d] = rk; e_dm[d] = mt;
      end
      if (room) begin
        pos = mc[d];
        for (int i = mc[d]-1; i >= 0; i--) if (rk < mr[d][i]) pos = i;
        for (int i = mc[d]; i > pos; i--) begin
          mr[d][i] = mr[d][i-1];
          mm[d][i] = mm[d][i-1];
        end
        mr[d][pos] = rk; mm[d][pos] = mt;
        mc[d]++;
        e_si[d]++;
      end
    end
    if (e_dv[d]) e_sd[d]++;
  endtask

  function automatic logic [PW-1:0] exp_pack(input int d);
    int si, sd;
`ifdef PIFO_REG_STATS_EN
    si = e_si[d]; sd = e_sd[d];
`else
    si = 0; sd = 0;
`endif
    return {4'(mc[d]), mc[d] == DEPTH, mc[d] == 0, mc[d] != 0,
            (mc[d] > 0) ? 8'(mr[d][0]) : 8'd0, (mc[d] > 0) ? 8'(mm[d][0]) : 8'd0,
            e_dv[d], 8'(e_dr[d]), 8'(e_dm[d]), 32'(si), 32'(sd)};
  endfunction

  function automatic logic [PW-1:0] act_pack(input int d);
    return {a_cnt[d], a_full[d], a_empty[d], a_vo[d], a_rank[d], a_meta[d],
            a_dv[d], a_drank[d], a_dmeta[d], a_si[d], a_sd[d]};
  endfunction

  task automatic cycle(input bit r, input bit ins, input bit rem,
                       input int rk, input int mt);
    rst = r;
    bt.insert = ins; bt.remove = rem; bt.rank_in = rk[RW-1:0]; bt.meta_in = mt[MW-1:0];
    bp.insert = ins; bp.remove = rem; bp.rank_in = rk[RW-1:0]; bp.meta_in = mt[MW-1:0];
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (r) begin
        mc[d] = 0; e_dv[d] = 1'b0; e_dr[d] = 0; e_dm[d] = 0; e_si[d] = 0; e_sd[d] = 0;
      end else model_step(d, ins, rem, rk, mt);
    end
    #1;
    rst = 1'b0;
    bt.insert = 1'b0; bt.remove = 1'b0;
    bp.insert = 1'b0; bp.remove = 1'b0;
  endtask

  task automatic test_reset();
    cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 1, 9, 9);
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (act_pack(d) !== exp_pack(d) || a_empty[d] !== 1'b1 || a_cnt[d] !== 4'd0) begin
        errs++;
        $display("FAIL reset d%0d got %h want %h", d, act_pack(d), exp_pack(d));
      end
    end
  endtask

  task automatic test_sort();
    int ins_r[7] = '{8, 87, 54, 76, 47, 68, 29};
    int heads[7] = '{8, 29, 47, 54, 68, 76, 87};
    for (int k = 0; k < 7; k++) begin
      cycle(0, 1, 0, ins_r[k], k);
      vectors++;
      if (act_pack(0) !== exp_pack(0) || a_cnt[0] !== 4'(k+1)) begin
        errs++;
        $display("FAIL sort_ins%0d got %h want %h", k, act_pack(0), exp_pack(0));
      end
    end
    for (int k = 0; k < 7; k++) begin
      vectors++;
      if (a_rank[0] !== 8'(heads[k]) || a_rank[1] !== 8'(heads[k])) begin
        errs++;
        $display("FAIL sort_head%0d got %0d/%0d want %0d", k, a_rank[0], a_rank[1], heads[k]);
      end
      cycle(0, 0, 1, 0, 0);
      vectors++;
      if (a_cnt[0] !== 4'(6-k) || a_cnt[1] !== 4'(6-k)) begin
        errs++;
        $display("FAIL sort_cnt%0d got %0d/%0d want %0d", k, a_cnt[0], a_cnt[1], 6-k);
      end
    end
    vectors++;
    if (a_empty[0] !== 1'b1 || a_vo[0] !== 1'b0 || a_rank[0] !== 8'd0) begin
      errs++;
      $display("FAIL sort_empty got e%0d v%0d r%0d want e1 v0 r0", a_empty[0], a_vo[0], a_rank[0]);
    end
  endtask

  task automatic test_ties();
    int metas[3] = '{'h10, 'h20, 'h30};
    cycle(1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) cycle(0, 1, 0, 5, metas[k]);
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (a_meta[0] !== 8'(metas[k]) || a_meta[1] !== 8'(metas[k])) begin
        errs++;
        $display("FAIL tie_meta%0d got %h/%h want %h", k, a_meta[0], a_meta[1], metas[k]);
      end
      cycle(0, 0, 1, 0, 0);
    end
    cycle(0, 0, 1, 0, 0);
    vectors++;
    if (a_cnt[0] !== 4'd0 || a_dv[0] !== 1'b0 || act_pack(1) !== exp_pack(1)) begin
      errs++;
      $display("FAIL tie_empty_rm got c%0d dv%0d want c0 dv0", a_cnt[0], a_dv[0]);
    end
  endtask

  task automatic test_simul();
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 0, 29, 1);
    cycle(0, 1, 0, 47, 2);
    cycle(0, 1, 1, 10, 3);
    vectors++;
    if (a_rank[0] !== 8'd10 || a_cnt[0] !== 4'd2 || a_dv[0] !== 1'b0) begin
      errs++;
      $display("FAIL simul_head got r%0d c%0d want r10 c2", a_rank[0], a_cnt[0]);
    end
    for (int k = 0; k < 6; k++) cycle(0, 1, 0, 50 + k, 4 + k);
    cycle(0, 1, 1, 10, 'h77);
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (a_cnt[d] !== 4'd8 || a_dv[d] !== 1'b0 || a_full[d] !== 1'b1 ||
          act_pack(d) !== exp_pack(d)) begin
        errs++;
        $display("FAIL simul_full d%0d got %h want %h", d, act_pack(d), exp_pack(d));
      end
    end
  endtask

  task automatic test_overflow();
    cycle(1, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) cycle(0, 1, 0, 10 + k, 'h40 + k);
    cycle(0, 1, 0, 3, 'hAA);
    vectors++;
    if (a_dv[0] !== 1'b1 || a_drank[0] !== 8'd3 || a_dmeta[0] !== 8'hAA || a_rank[0] !== 8'd10) begin
      errs++;
      $display("FAIL tail_drop got dv%0d dr%0d dm%h h%0d want dv1 dr3 dmaa h10",
               a_dv[0], a_drank[0], a_dmeta[0], a_rank[0]);
    end
    vectors++;
    if (a_dv[1] !== 1'b1 || a_drank[1] !== 8'd17 || a_dmeta[1] !== 8'h47 ||
        a_rank[1] !== 8'd3 || a_cnt[1] !== 4'd8) begin
      errs++;
      $display("FAIL pushout_evict got dv%0d dr%0d dm%h h%0d c%0d want dv1 dr17 dm47 h3 c8",
               a_dv[1], a_drank[1], a_dmeta[1], a_rank[1], a_cnt[1]);
    end
    cycle(0, 1, 0, 16, 'h55);
    vectors++;
    if (a_dv[1] !== 1'b1 || a_drank[1] !== 8'd16 || a_dmeta[1] !== 8'h55 || a_rank[1] !== 8'd3) begin
      errs++;
      $display("FAIL pushout_equal got dv%0d dr%0d dm%h h%0d want dv1 dr16 dm55 h3",
               a_dv[1], a_drank[1], a_dmeta[1], a_rank[1]);
    end
    cycle(0, 0, 0, 0, 0);
    vectors++;
    if (a_dv[0] !== 1'b0 || a_dv[1] !== 1'b0 || a_drank[1] !== 8'd16) begin
      errs++;
      $display("FAIL drop_hold got dv%0d/%0d dr%0d want dv0/0 dr16", a_dv[0], a_dv[1], a_drank[1]);
    end
`ifdef PIFO_REG_STATS_EN
    vectors++;
    if (a_si[1] !== 32'd9 || a_sd[1] !== 32'd2 || a_si[0] !== 32'd8 || a_sd[0] !== 32'd2) begin
      errs++;
      $display("FAIL stats got %0d/%0d %0d/%0d want 8/2 9/2", a_si[0], a_sd[0], a_si[1], a_sd[1]);
    end
`else
    vectors++;
    if (a_si[1] !== 32'd0 || a_sd[1] !== 32'd0 || a_si[0] !== 32'd0 || a_sd[0] !== 32'd0) begin
      errs++;
      $display("FAIL stats_off got %0d/%0d %0d/%0d want 0", a_si[0], a_sd[0], a_si[1], a_sd[1]);
    end
`endif
  endtask

  task automatic test_reset_mid();
    // queues are full here; the insert would otherwise drop
    cycle(1, 1, 0, 1, 'h99);
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (a_cnt[d] !== 4'd0 || a_dv[d] !== 1'b0 || a_drank[d] !== 8'd0 ||
          a_empty[d] !== 1'b1 || act_pack(d) !== exp_pack(d)) begin
        errs++;
        $display("FAIL reset_mid d%0d got %h want %h", d, act_pack(d), exp_pack(d));
      end
    end
  endtask

  task automatic test_random();
    int p, sel, rk;
    bit r, ins, rem;
    for (int n = 0; n < 600; n++) begin
      p   = ((n / 60) % 2 == 0) ? 75 : 35;
      r   = ($urandom_range(0, 249) == 0);
      ins = ($urandom_range(0, 99) < p);
      rem = ($urandom_range(0, 99) < 100 - p);
      sel = $urandom_range(0, 9);
      rk  = (sel == 0) ? 0 : (sel == 1) ? 255 : $urandom_range(0, 15);
      cycle(r, ins, rem, rk, $urandom_range(0, 255));
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (act_pack(d) !== exp_pack(d)) begin
          errs++;
          $display("FAIL random n%0d d%0d got %h want %h", n, d, act_pack(d), exp_pack(d));
        end
      end
    end
  endtask

  initial begin
    bt.insert = 1'b0; bt.remove = 1'b0; bt.rank_in = '0; bt.meta_in = '0;
    bp.insert = 1'b0; bp.remove = 1'b0; bp.rank_in = '0; bp.meta_in = '0;
    for (int d = 0; d < 2; d++) begin
      mc[d] = 0; e_dv[d] = 1'b0; e_dr[d] = 0; e_dm[d] = 0; e_si[d] = 0; e_sd[d] = 0;
    end
    test_reset();
    test_sort();
    test_ties();
    test_simul();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/pifo_reg_pushout.md
Name: pifo_reg_pushout

Overview:
- Register-array Push-In-First-Out queue holding up to 2**L2_MAX_SIZE entries of {rank, meta}, kept sorted so the head is always the best rank.
- Successor to the basic register PIFO. Adds: occupancy and full/empty status, defined simultaneous insert+remove, FIFO tie-breaking, selectable overflow policy (tail-drop or push-out of the worst entry) with a drop report port.
- Sits between the rank computation stage and the egress scheduler in the SUME switch datapath.

Parameters:
- L2_MAX_SIZE, 3, log2 of depth; DEPTH = 2**L2_MAX_SIZE.
- RANK_WIDTH, 8, rank bits (unsigned).
- META_WIDTH, 8, metadata bits carried opaquely.
- ORDER, "MIN", "MIN" = smallest rank dequeued first; "MAX" = largest first.
- OVF_MODE, "TAIL", "TAIL" = drop arriving entry when full; "PUSHOUT" = evict worst entry if the arriving entry is strictly better.
- STAT_WIDTH, 32, width of the optional statistics counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- insert  in  1  enqueue request, single-cycle qualified
- remove  in  1  dequeue head request
- rank_in  in  RANK_WIDTH  rank of entry being inserted
- meta_in  in  META_WIDTH  metadata of entry being inserted
- rank_out  out  RANK_WIDTH  head rank
- meta_out  out  META_WIDTH  head metadata
- valid_out  out  1  head valid (queue non-empty)
- count  out  L2_MAX_SIZE+1  occupancy, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- drop_valid  out  1  one-cycle pulse: an entry was discarded
- drop_rank  out  RANK_WIDTH  rank of discarded entry
- drop_meta  out  META_WIDTH  meta of discarded entry
- stat_insert_cnt  out  STAT_WIDTH  accepted inserts (optional feature)
- stat_drop_cnt  out  STAT_WIDTH  discarded entries (optional feature)

Behaviour:
- Reset: all slots invalid. count=0, empty=1, full=0, valid_out=0. rank_out, meta_out, drop_* = 0. Stats = 0. Reset mid-operation discards all contents in one cycle; drop_valid is not pulsed for flushed entries.
- All outputs are driven from registers. An operation sampled at edge N is visible immediately after edge N (1-cycle latency). Head outputs are 0 when valid_out=0.
- Ordering: slot 0 = head. "Better" means strictly lower rank (MIN) or strictly higher rank (MAX). An inserted entry goes behind all entries of equal rank (FIFO among ties).
- remove with empty=1: ignored, no state change.
- insert with full=0: entry placed, count+1.
- remove alone, non-empty: head popped, entries shift up, count-1.
- insert and remove together, non-empty:
  - The head visible that cycle is popped.
  - The new entry is sorted into the remaining entries; count is unchanged.
  - This holds even when full; no drop occurs.
- insert and remove together, empty: remove ignored, insert proceeds, count becomes 1.
- insert alone, full, OVF_MODE="TAIL": arriving entry discarded. drop_valid=1 and drop_rank/meta = arriving entry for one cycle. Contents unchanged.
- insert alone, full, OVF_MODE="PUSHOUT":
  - If the arriving entry is better than the tail (slot DEPTH-1): the tail is evicted and reported on drop_*, and the arriving entry is sorted in. count stays DEPTH.
  - Otherwise (worse or equal): the arriving entry is dropped, as in TAIL.
- drop_valid is 0 in every other cycle. drop_rank/meta hold their last value.
- Rank compare is unsigned with no wrap-around handling. Rank 0 and rank 2**RANK_WIDTH-1 are ordinary values.

Optional Feature:
- PIFO_REG_STATS_EN defined:
  - stat_insert_cnt increments on each accepted insert, including push-out inserts.
  - stat_drop_cnt increments on each drop_valid pulse.
  - Both counters saturate at all-ones and clear on rst.
- Undefined: both ports are tied to 0 and no counter logic is synthesised.

Test Plan:
- ORDER=MIN, DEPTH=8: insert ranks 8,87,54,76,47,68,29 on separate cycles, then 7 removes -> heads in order 8,29,47,54,68,76,87; count goes 7→0; empty=1 after the last remove.
- Ties: insert (rank 5, meta 0x10), then (5, 0x20), then (5, 0x30); remove ×3 -> meta_out 0x10, 0x20, 0x30; an extra remove on empty leaves count=0, no drop.
- Simultaneous: queue holds {29,47}; insert 10 with remove in the same cycle -> 29 popped, next head 10, count stays 2. Same stimulus on a full queue -> count 8, drop_valid=0.
- OVF_MODE=TAIL, full with ranks 10..17: insert (rank 3, 0xAA) -> drop_valid=1, drop_rank=3, drop_meta=0xAA; head remains 10.
- OVF_MODE=PUSHOUT, full with ranks 10..17: insert rank 3 -> drop_rank=17, head 3, count 8. Then insert rank 16 (equal to the new tail) -> drop_rank=16 (the arriving entry); contents unchanged.
- With PIFO_REG_STATS_EN: after the PUSHOUT scenario, stat_insert_cnt=9 and stat_drop_cnt=2. Assert rst mid-stream -> all outputs at reset values the next cycle, and no drop pulse.
